// File: rtl/cei_mochila_pkg.sv
// -----------------------------------------------------------------------------
// cei_mochila_pkg
//   Shared types for the safe-CPU wrapper control slice.
//   - interrupt_type_e : LEVEL or EDGE completion interrupt flavour
//   - cb_seq_state_e   : run-sequencer state encoding (IDLE/RUN/DRAIN/DONE)
//   - helpers that reduce the per-hart sleep/debug vectors against a hart mask
//     (vectors are passed zero-extended to MAX_HARTS bits)
// -----------------------------------------------------------------------------
package cei_mochila_pkg;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } interrupt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cb_seq_state_e;

    localparam int unsigned MAX_HARTS   = 8;
    localparam int unsigned RUN_CNT_W   = 32;
    localparam logic [RUN_CNT_W-1:0] RUN_CNT_MAX = 32'hFFFF_FFFF;

    // True when every hart selected by mask is asleep. Unselected harts
    // (including zero-extension padding) count as asleep.
    function automatic logic all_masked_asleep(input logic [MAX_HARTS-1:0] sleep,
                                               input logic [MAX_HARTS-1:0] mask);
        return &(sleep | ~mask);
    endfunction

    // True when any hart selected by mask is halted in debug mode.
    function automatic logic any_masked_debug(input logic [MAX_HARTS-1:0] dbg,
                                              input logic [MAX_HARTS-1:0] mask);
        return |(dbg & mask);
    endfunction

endpackage

// File: rtl/cb_pulse_gen.sv
// -----------------------------------------------------------------------------
// cb_pulse_gen
//   Stretches a single-cycle trigger into a registered pulse of exactly
//   PULSE_W cycles, starting the cycle after the trigger.
//   Ports:
//     clk_i   : clock
//     rst_ni  : asynchronous active-low reset (aborts any pulse in progress)
//     trig_i  : single-cycle trigger
//     pulse_o : registered pulse output
//   PULSE_W must be >= 1.
// -----------------------------------------------------------------------------
module cb_pulse_gen #(
    parameter int unsigned PULSE_W = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic pulse_o
);

    // The counter holds the number of pulse cycles still to come after the
    // current one, so it only needs to reach PULSE_W-1.
    localparam int unsigned CntW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (trig_i) begin
            cnt_d   = CntW'(PULSE_W - 1);
            pulse_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - 1'b1;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cb_safe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cb_safe_seq_ctrl
//   Run-sequencer for the safe-CPU wrapper. Launches an N-hart routine,
//   waits for EndSw plus sleep on all masked harts, enforces an optional
//   cycle timeout and raises a LEVEL or EDGE completion interrupt.
//
//   Handshake: start_set_i and intr_clr_i are single-cycle strobes from the
//   register file with no back-pressure; a strobe is consumed in the cycle it
//   is high if the current state accepts it, otherwise it is dropped.
//
//   Ports:
//     clk_i, rst_ni      : clock, asynchronous active-low reset
//     start_set_i        : launch request (honoured in IDLE with mask != 0)
//     boot_addr_i        : boot address, latched on launch
//     hart_mask_i        : harts that must be asleep for completion
//     timeout_i          : cycle limit, 0 disables
//     intr_en_i          : interrupt enable
//     intr_clr_i         : clears status in DONE and returns to IDLE
//     end_sw_i           : routine-finished flag from the wrapper
//     sleep_i            : per-hart sleep
//     debug_mode_i       : per-hart debug mode (freezes the cycle counter)
//     start_o            : Start to the wrapper (high in RUN)
//     boot_addr_o        : latched boot address
//     busy_o             : RUN or DRAIN
//     done_o, timeout_o  : sticky completion / timeout status
//     state_o            : current state encoding (observability)
//     run_cycles_o       : saturating cycle count for RUN+DRAIN
//     interrupt_o        : completion interrupt
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cb_safe_seq_ctrl
    import cei_mochila_pkg::*;
#(
    parameter int unsigned     NHARTS    = 3,
    parameter interrupt_type_e INTC_TYPE = LEVEL,
    parameter int unsigned     PULSE_W   = 2,
    parameter int unsigned     TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_set_i,
    input  logic [31:0]          boot_addr_i,
    input  logic [NHARTS-1:0]    hart_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic                 intr_en_i,
    input  logic                 intr_clr_i,
    input  logic                 end_sw_i,
    input  logic [NHARTS-1:0]    sleep_i,
    input  logic [NHARTS-1:0]    debug_mode_i,
    output logic                 start_o,
    output logic [31:0]          boot_addr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [1:0]           state_o,
    output logic [31:0]          run_cycles_o,
    output logic                 interrupt_o
);

    cb_seq_state_e         state_q, state_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  end_sw_q;
    logic [31:0]           boot_addr_q, boot_addr_d;
    logic [RUN_CNT_W-1:0]  run_cycles_q, run_cycles_d;

    logic launch;
    logic end_sw_rise;
    logic completion;
    logic timeout_hit;
    logic dbg_hold;
    logic active;

    assign launch      = start_set_i && (hart_mask_i != '0);
    // The edge register samples end_sw_i in every state, so a flag that was
    // already high before launch never looks like a fresh edge.
    assign end_sw_rise = end_sw_i && !end_sw_q;
    assign completion  = end_sw_i &&
                         all_masked_asleep(MAX_HARTS'(sleep_i), MAX_HARTS'(hart_mask_i));
    assign timeout_hit = (timeout_i != '0) && (run_cycles_q >= RUN_CNT_W'(timeout_i));
    assign dbg_hold    = any_masked_debug(MAX_HARTS'(debug_mode_i), MAX_HARTS'(hart_mask_i));
    assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        boot_addr_d  = boot_addr_q;
        run_cycles_d = run_cycles_q;

        // Counts every cycle spent in RUN/DRAIN, including the one that
        // leaves for DONE; frozen while a masked hart is in debug.
        if (active && !dbg_hold && (run_cycles_q != RUN_CNT_MAX)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d      = ST_RUN;
                    boot_addr_d  = boot_addr_i;
                    run_cycles_d = '0;
                end
            end
            ST_RUN: begin
                if (timeout_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else if (end_sw_rise) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Completion takes priority over a coincident timeout.
                if (completion) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (intr_clr_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            end_sw_q     <= 1'b0;
            boot_addr_q  <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            end_sw_q     <= end_sw_i;
            boot_addr_q  <= boot_addr_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;
    assign boot_addr_o  = boot_addr_q;
    assign run_cycles_o = run_cycles_q;

    if (INTC_TYPE == EDGE) begin : g_edge_irq
        // Fires only on the transition into DONE; enabling later in DONE
        // does not produce a pulse.
        logic trig;
        assign trig = intr_en_i && (state_d == ST_DONE) && (state_q != ST_DONE);

        cb_pulse_gen #(
            .PULSE_W (PULSE_W)
        ) u_pulse_gen (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .trig_i  (trig),
            .pulse_o (interrupt_o)
        );
    end else begin : g_level_irq
        // Built from the next-state status so the interrupt rises in the
        // same cycle as done_o/timeout_o.
        logic irq_q, irq_d;
        assign irq_d = intr_en_i && (done_d || timeout_d);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                irq_q <= 1'b0;
            end else begin
                irq_q <= irq_d;
            end
        end

        assign interrupt_o = irq_q;
    end

endmodule
